// File: rtl/dma_bus_arbiter.sv
// Shared memory bus arbiter for DSP DMA, blitter and CPU.
// Fixed priority DSP > blitter > CPU. A starvation counter forces a CPU win, and grants are never pulled mid-cycle.
module dma_bus_arbiter #(
    parameter int TURN_CYCLES  = 1,
    parameter int STARVE_LIMIT = 8
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       DSPBRQ,
    input  logic       BLTBRQ,
    input  logic       CPUBRQ,
    input  logic       DMAACTIVE,
    input  logic       BLTACTIVE,
    input  logic       WAIT,
    output logic       DSPBAK,
    output logic       DSPBAKL,
    output logic       BLTBAK,
    output logic       CPUBAK,
    output logic [1:0] ARBSTATE,
    output logic       STARVED
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TURN = 2'd1,
        ST_OWN  = 2'd2,
        ST_BAD  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_DSP  = 2'd1,
        OWN_BLT  = 2'd2,
        OWN_CPU  = 2'd3
    } owner_e;

    localparam logic [1:0] TURN_LOAD  = 2'(TURN_CYCLES - 1);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    state_e     state_q, state_d;
    owner_e     owner_q, owner_d;
    logic [1:0] turn_q, turn_d;
    logic [3:0] starve_q, starve_d;
    logic       dspbak_q, dspbak_d;
    logic       dspbakl_q, dspbakl_d;
    logic       bltbak_q, bltbak_d;
    logic       cpubak_q, cpubak_d;
    logic       starved_q, starved_d;

    owner_e     winner;
    logic       any_req;
    logic       drop;

    always_comb begin
        any_req = DSPBRQ | BLTBRQ | CPUBRQ;
        if (starved_q && CPUBRQ) winner = OWN_CPU;
        else if (DSPBRQ)         winner = OWN_DSP;
        else if (BLTBRQ)         winner = OWN_BLT;
        else                     winner = OWN_CPU;
    end

    // Release and preemption share one path: either way the ack drops and we go back through IDLE.
    always_comb begin
        case (owner_q)
            OWN_DSP: drop = !DSPBRQ && !DMAACTIVE;
            OWN_BLT: drop = (!BLTBRQ || DSPBRQ) && !BLTACTIVE;
            OWN_CPU: drop = !CPUBRQ || ((DSPBRQ || BLTBRQ) && !starved_q);
            default: drop = 1'b1;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        turn_d   = turn_q;
        starve_d = starve_q;
        dspbak_d = dspbak_q;
        bltbak_d = bltbak_q;
        cpubak_d = cpubak_q;

        if (state_q == ST_BAD) begin
            state_d  = ST_IDLE;
            owner_d  = OWN_NONE;
            turn_d   = 2'd0;
            dspbak_d = 1'b0;
            bltbak_d = 1'b0;
            cpubak_d = 1'b0;
        end else if (!WAIT) begin
            case (state_q)
                ST_IDLE: begin
                    dspbak_d = 1'b0;
                    bltbak_d = 1'b0;
                    cpubak_d = 1'b0;
                    if (!CPUBRQ) starve_d = 4'd0;
                    if (any_req) begin
                        owner_d = winner;
                        turn_d  = TURN_LOAD;
                        state_d = ST_TURN;
                    end
                end
                ST_TURN: begin
                    if (turn_q == 2'd0) begin
                        state_d  = ST_OWN;
                        dspbak_d = (owner_q == OWN_DSP);
                        bltbak_d = (owner_q == OWN_BLT);
                        cpubak_d = (owner_q == OWN_CPU);
                        if (owner_q == OWN_CPU)
                            starve_d = 4'd0;
                        else if (CPUBRQ && starve_q != STARVE_MAX)
                            starve_d = starve_q + 4'd1;
                    end else begin
                        turn_d = turn_q - 2'd1;
                    end
                end
                ST_OWN: begin
                    if (drop) begin
                        state_d  = ST_IDLE;
                        owner_d  = OWN_NONE;
                        dspbak_d = 1'b0;
                        bltbak_d = 1'b0;
                        cpubak_d = 1'b0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        dspbakl_d = ~dspbak_d;
        starved_d = (starve_d == STARVE_MAX);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_NONE;
            turn_q    <= 2'd0;
            starve_q  <= 4'd0;
            dspbak_q  <= 1'b0;
            dspbakl_q <= 1'b1;
            bltbak_q  <= 1'b0;
            cpubak_q  <= 1'b0;
            starved_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            turn_q    <= turn_d;
            starve_q  <= starve_d;
            dspbak_q  <= dspbak_d;
            dspbakl_q <= dspbakl_d;
            bltbak_q  <= bltbak_d;
            cpubak_q  <= cpubak_d;
            starved_q <= starved_d;
        end
    end

    assign DSPBAK   = dspbak_q;
    assign DSPBAKL  = dspbakl_q;
    assign BLTBAK   = bltbak_q;
    assign CPUBAK   = cpubak_q;
    assign ARBSTATE = state_q;
    assign STARVED  = starved_q;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Directed bench for dma_bus_arbiter: expected output vectors are queued as each step is driven.
// Each vector is popped and checked after the following clock edge.
module tb_dma_bus_arbiter;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       DSPBRQ = 1'b0, BLTBRQ = 1'b0, CPUBRQ = 1'b0;
    logic       DMAACTIVE = 1'b0, BLTACTIVE = 1'b0, WAIT = 1'b0;
    logic       DSPBAK, DSPBAKL, BLTBAK, CPUBAK, STARVED;
    logic [1:0] ARBSTATE;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string      tag;
        logic [7:0] exp;
    } sb_t;
    sb_t sbq[$];

    dma_bus_arbiter #(.TURN_CYCLES(1), .STARVE_LIMIT(2)) dut (
        .CLK(CLK), .RESET(RESET),
        .DSPBRQ(DSPBRQ), .BLTBRQ(BLTBRQ), .CPUBRQ(CPUBRQ),
        .DMAACTIVE(DMAACTIVE), .BLTACTIVE(BLTACTIVE), .WAIT(WAIT),
        .DSPBAK(DSPBAK), .DSPBAKL(DSPBAKL), .BLTBAK(BLTBAK), .CPUBAK(CPUBAK),
        .ARBSTATE(ARBSTATE), .STARVED(STARVED)
    );

    always #5 CLK = ~CLK;

    // Vector layout: {DSPBAK, BLTBAK, CPUBAK, DSPBAKL, ARBSTATE, STARVED}
    function automatic logic [7:0] ex(input logic [2:0] ack, input logic [1:0] st, input logic stv);
        return {ack, ~ack[2], st, stv};
    endfunction

    task automatic push(input logic [7:0] e, input string tag);
        sb_t s;
        s.tag = tag;
        s.exp = e;
        sbq.push_back(s);
    endtask

    task automatic check_out();
        sb_t        s;
        logic [7:0] obs;
        s   = sbq.pop_front();
        obs = {DSPBAK, BLTBAK, CPUBAK, DSPBAKL, ARBSTATE, STARVED};
        tests++;
        assert (obs === s.exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", s.tag, obs, s.exp);
        end
    endtask

    // in = {DSPBRQ, BLTBRQ, CPUBRQ, DMAACTIVE, BLTACTIVE, WAIT}, applied for the next edge
    task automatic cyc(input logic [5:0] in, input logic [2:0] ack, input logic [1:0] st,
                       input logic stv, input string tag);
        {DSPBRQ, BLTBRQ, CPUBRQ, DMAACTIVE, BLTACTIVE, WAIT} = in;
        push(ex(ack, st, stv), tag);
        @(posedge CLK);
        #1;
        check_out();
    endtask

    task automatic do_reset(input string tag);
        RESET = 1'b1;
        {DSPBRQ, BLTBRQ, CPUBRQ, DMAACTIVE, BLTACTIVE, WAIT} = 6'b0;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        push(ex(3'b000, 2'd0, 1'b0), tag);
        check_out();
    endtask

    initial begin
        // Single DSP grant and release
        do_reset("t1_reset");
        cyc(6'b100000, 3'b000, 2'd1, 1'b0, "t1_turn");
        cyc(6'b100100, 3'b100, 2'd2, 1'b0, "t1_own");
        cyc(6'b100100, 3'b100, 2'd2, 1'b0, "t1_hold");
        cyc(6'b000100, 3'b100, 2'd2, 1'b0, "t1_dmaactive_hold");
        cyc(6'b000000, 3'b000, 2'd0, 1'b0, "t1_release");
        cyc(6'b000000, 3'b000, 2'd0, 1'b0, "t1_idle");

        // All three requesting: DSP, then blitter, then CPU
        do_reset("t2_reset");
        cyc(6'b111000, 3'b000, 2'd1, 1'b0, "t2_turn_dsp");
        cyc(6'b111000, 3'b100, 2'd2, 1'b0, "t2_own_dsp");
        cyc(6'b011000, 3'b000, 2'd0, 1'b0, "t2_rel_dsp");
        cyc(6'b011000, 3'b000, 2'd1, 1'b0, "t2_turn_blt");
        cyc(6'b011000, 3'b010, 2'd2, 1'b1, "t2_own_blt");
        cyc(6'b001000, 3'b000, 2'd0, 1'b1, "t2_rel_blt");
        cyc(6'b001000, 3'b000, 2'd1, 1'b1, "t2_turn_cpu");
        cyc(6'b001000, 3'b001, 2'd2, 1'b0, "t2_own_cpu");
        cyc(6'b000000, 3'b000, 2'd0, 1'b0, "t2_rel_cpu");

        // CPU held by WAIT while DSP requests
        do_reset("t3_reset");
        cyc(6'b001000, 3'b000, 2'd1, 1'b0, "t3_turn_cpu");
        cyc(6'b001000, 3'b001, 2'd2, 1'b0, "t3_own_cpu");
        for (int i = 0; i < 3; i++)
            cyc(6'b101001, 3'b001, 2'd2, 1'b0, "t3_wait_hold");
        cyc(6'b101000, 3'b000, 2'd0, 1'b0, "t3_preempt_cpu");
        cyc(6'b101000, 3'b000, 2'd1, 1'b0, "t3_turn_dsp");
        cyc(6'b101000, 3'b100, 2'd2, 1'b0, "t3_own_dsp");

        // Blitter mid-cycle blocks DSP preemption
        do_reset("t4_reset");
        cyc(6'b010000, 3'b000, 2'd1, 1'b0, "t4_turn_blt");
        cyc(6'b010010, 3'b010, 2'd2, 1'b0, "t4_own_blt");
        for (int i = 0; i < 2; i++)
            cyc(6'b110010, 3'b010, 2'd2, 1'b0, "t4_bltactive_hold");
        cyc(6'b110000, 3'b000, 2'd0, 1'b0, "t4_preempt_blt");
        cyc(6'b110000, 3'b000, 2'd1, 1'b0, "t4_turn_dsp");
        cyc(6'b110000, 3'b100, 2'd2, 1'b0, "t4_own_dsp");

        // Starvation with limit 2: CPU forced in over a pending DSP request
        do_reset("t5_reset");
        cyc(6'b101000, 3'b000, 2'd1, 1'b0, "t5_turn_dsp");
        cyc(6'b101000, 3'b100, 2'd2, 1'b0, "t5_own_dsp");
        cyc(6'b011000, 3'b000, 2'd0, 1'b0, "t5_rel_dsp_blt_req");
        cyc(6'b011000, 3'b000, 2'd1, 1'b0, "t5_turn_blt");
        cyc(6'b111000, 3'b010, 2'd2, 1'b1, "t5_own_blt_starved");
        cyc(6'b101000, 3'b000, 2'd0, 1'b1, "t5_rel_blt");
        cyc(6'b101000, 3'b000, 2'd1, 1'b1, "t5_turn_cpu_forced");
        cyc(6'b101000, 3'b001, 2'd2, 1'b0, "t5_own_cpu_clear");
        cyc(6'b101000, 3'b000, 2'd0, 1'b0, "t5_cpu_preempted");

        // Asynchronous reset in the middle of a DSP grant
        do_reset("t6_reset");
        cyc(6'b100000, 3'b000, 2'd1, 1'b0, "t6_turn_dsp");
        cyc(6'b100000, 3'b100, 2'd2, 1'b0, "t6_own_dsp");
        #3;
        RESET = 1'b1;
        #1;
        push(ex(3'b000, 2'd0, 1'b0), "t6_async_reset");
        check_out();
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        push(ex(3'b000, 2'd0, 1'b0), "t6_reset_release");
        check_out();
        cyc(6'b100001, 3'b000, 2'd0, 1'b0, "t6_wait_in_idle");
        cyc(6'b100000, 3'b000, 2'd1, 1'b0, "t6_rearb_turn");
        cyc(6'b100000, 3'b100, 2'd2, 1'b0, "t6_rearb_own");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dma_bus_arbiter.md
Name: dma_bus_arbiter

Overview:
- Arbitrates the shared system memory bus between three requesters: DSP DMA, blitter and CPU.
- Issues a single registered bus-acknowledge to exactly one requester at a time.
- Owns the DSPBAK/DSPBAKL pair consumed by the DSP DMA memory-cycle sequencer. It never removes a grant while that sequencer or the blitter is mid-cycle, or while memory WAIT is asserted.
- Fixed priority DSP > blitter > CPU, with an anti-starvation counter that guarantees CPU progress.

Parameters:
TURN_CYCLES, 1, number of dead cycles (all acks low) between arbitration win and grant assertion; legal range 1..3
STARVE_LIMIT, 8, consecutive non-CPU grants allowed while CPUBRQ is pending before CPU is forced to win; legal range 1..15

Ports:
CLK  input  1  system clock, all state on rising edge
RESET  input  1  asynchronous, active-high reset
DSPBRQ  input  1  DSP DMA bus request, level, held until acknowledged use completes
BLTBRQ  input  1  blitter bus request, level
CPUBRQ  input  1  CPU bus request, level
DMAACTIVE  input  1  high while DSP DMA memory-cycle sequencer is in a non-idle state
BLTACTIVE  input  1  high while blitter is mid memory cycle
WAIT  input  1  memory wait; no grant may change while high
DSPBAK  output  1  DSP bus acknowledge
DSPBAKL  output  1  inverse of DSPBAK, registered, never equal to DSPBAK
BLTBAK  output  1  blitter bus acknowledge
CPUBAK  output  1  CPU bus acknowledge
ARBSTATE  output  2  current state: 0 IDLE, 1 TURN, 2 OWN
STARVED  output  1  high while the starvation counter equals STARVE_LIMIT

Behaviour:
- Reset (async, any time including mid-cycle):
  - State = IDLE; owner cleared; turn counter = 0; starvation counter = 0.
  - DSPBAK=0, DSPBAKL=1, BLTBAK=0, CPUBAK=0, ARBSTATE=0, STARVED=0.
- All outputs are registered. At most one of DSPBAK/BLTBAK/CPUBAK is high in any cycle.
- IDLE:
  - If any BRQ is high and WAIT=0: latch the winner, load turn counter = TURN_CYCLES-1, go to TURN.
  - Winner rule: if STARVED=1 and CPUBRQ=1, CPU wins; otherwise DSP > BLT > CPU.
  - With no request or WAIT=1, stay in IDLE.
- TURN:
  - All acks stay low.
  - Counter decrements each cycle; at 0, go to OWN and assert the winner's ack in the same registered update. The ack is therefore first visible TURN_CYCLES+1 cycles after the request is sampled in IDLE.
  - A request dropping during TURN does not abort; the grant is still issued and released per the OWN rules.
- OWN, release condition (evaluated each cycle):
  - DSP owner: DSPBRQ=0 and DMAACTIVE=0 and WAIT=0.
  - BLT owner: BLTBRQ=0 and BLTACTIVE=0 and WAIT=0.
  - CPU owner: CPUBRQ=0 and WAIT=0.
- OWN, preemption:
  - CPU owner: if DSPBRQ or BLTBRQ is high and WAIT=0, CPU is released even with CPUBRQ still high, unless STARVED=1.
  - Blitter owner: if DSPBRQ=1, BLTACTIVE=0 and WAIT=0, the blitter is released.
  - DSP owner: never preempted.
- On release or preemption: ack drops next edge, state goes to IDLE. There is always at least one IDLE cycle between owners.
- Starvation counter:
  - On each OWN entry with a non-CPU winner while CPUBRQ=1, increment, saturating at STARVE_LIMIT.
  - On any CPU grant, or when CPUBRQ=0 in IDLE, clear to 0.
  - STARVED = (count == STARVE_LIMIT), registered.
- Simultaneous events:
  - Release and a new request in the same cycle: release wins; the new request is arbitrated in the following IDLE.
  - WAIT high freezes state, counters and acks completely.
- ARBSTATE reflects the registered state; encoding 3 is unreachable and, if ever entered, returns to IDLE on the next edge.

Test Plan:
- Reset then DSPBRQ=1 at cycle 0, TURN_CYCLES=1 -> ARBSTATE 0,1,2; DSPBAK=1, DSPBAKL=0 at cycle 2; drop DSPBRQ with DMAACTIVE=0 -> DSPBAK=0 next edge, ARBSTATE=0.
- All three BRQ high together -> DSP granted first; after DSP release, blitter granted; after blitter release, CPU granted; never two acks high.
- CPU owns, DSPBRQ rises with WAIT=1 for 3 cycles -> CPUBAK held 3 cycles; WAIT falls -> CPUBAK=0 next edge, DSPBAK=1 after IDLE+TURN.
- Blitter owns with BLTACTIVE=1, DSPBRQ=1 -> BLTBAK held; BLTACTIVE falls -> BLTBAK drops, DSP granted.
- STARVE_LIMIT=2, CPUBRQ held, DSP/BLT alternately re-requesting -> after 2 non-CPU grants STARVED=1; CPU wins next arbitration despite DSPBRQ=1; STARVED=0 after CPU grant.
- RESET asserted while ARBSTATE=2, DSPBAK=1, asynchronously mid-cycle -> DSPBAK=0, DSPBAKL=1, ARBSTATE=0 immediately; request re-arbitrated after RESET falls.
